// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side signal bundle for the ID-stage hazard/stall controller
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_Rs;
  logic [4:0]       IF_ID_Rt;
  logic             IF_ID_usesRt;
  logic             IF_ID_branch;
  logic [4:0]       ID_EX_Rdest;
  logic             ID_EX_regW;
  logic             ID_EX_memRead;
  logic [4:0]       EX_MEM_Rd;
  logic             EX_MEM_memRead;
  logic             branch_taken;
  logic             mem_wait;
  logic             pc_write;
  logic             IF_ID_write;
  logic             ID_EX_bubble;
  logic             IF_ID_flush;
  logic             pipe_hold;
  logic             stall_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_usesRt, IF_ID_branch, ID_EX_Rdest, ID_EX_regW,
           ID_EX_memRead, EX_MEM_Rd, EX_MEM_memRead, branch_taken, mem_wait,
    input  pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_hold, stall_busy,
           stall_cycles, flush_count
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_usesRt, IF_ID_branch, ID_EX_Rdest, ID_EX_regW,
           ID_EX_memRead, EX_MEM_Rd, EX_MEM_memRead, branch_taken, mem_wait,
    output pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_hold, stall_busy,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID-stage load-use / branch-operand stall controller with perf counters
// Hazards are detected only in RUN; STALL counts down the committed length without looking at inputs.
module hazard_stall_ctrl #(
  parameter int CNT_W             = 16,
  parameter int LOAD_BRANCH_STALL = 2
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_ctrl_if.slave bus
);
  localparam logic [1:0] LBS = 2'(LOAD_BRANCH_STALL);

  typedef enum logic {RUN, STALL} state_t;

  state_t           state_q;
  logic [1:0]       rem_q;
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_count_q;

  logic       match_ex;
  logic       match_mem;
  logic [1:0] haz_n;
  logic       stall_cyc;
  logic       flush_cyc;

  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    match_ex  = reg_match(bus.ID_EX_Rdest, bus.IF_ID_Rs, bus.IF_ID_Rt, bus.IF_ID_usesRt);
    match_mem = reg_match(bus.EX_MEM_Rd, bus.IF_ID_Rs, bus.IF_ID_Rt, bus.IF_ID_usesRt);
    haz_n     = 2'd0;
    if (bus.IF_ID_branch) begin
      // A load in EX feeding an ID branch is the only multi-cycle case.
      if (bus.ID_EX_memRead && match_ex)       haz_n = LBS;
      else if (bus.ID_EX_regW && match_ex)     haz_n = 2'd1;
      else if (bus.EX_MEM_memRead && match_mem) haz_n = 2'd1;
    end else if (bus.ID_EX_memRead && match_ex) begin
      haz_n = 2'd1;
    end
  end

  assign stall_cyc = !bus.mem_wait && ((state_q == STALL) || (haz_n != 2'd0));
  assign flush_cyc = !bus.mem_wait && !stall_cyc && bus.branch_taken;

  assign bus.pc_write     = !bus.mem_wait && !stall_cyc;
  assign bus.IF_ID_write  = !bus.mem_wait && !stall_cyc;
  assign bus.ID_EX_bubble = stall_cyc;
  assign bus.IF_ID_flush  = flush_cyc;
  assign bus.pipe_hold    = bus.mem_wait;
  assign bus.stall_busy   = (state_q == STALL);
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      rem_q          <= 2'd0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!bus.mem_wait) begin
        if (state_q == RUN) begin
          if (haz_n > 2'd1) begin
            state_q <= STALL;
            rem_q   <= haz_n - 2'd1;
          end
        end else if (rem_q == 2'd1) begin
          state_q <= RUN;
          rem_q   <= 2'd0;
        end else begin
          rem_q <= rem_q - 2'd1;
        end
      end
      if (stall_cyc && !(&stall_cycles_q)) stall_cycles_q <= stall_cycles_q + 1'b1;
      if (flush_cyc && !(&flush_count_q))  flush_count_q  <= flush_count_q + 1'b1;
    end
  end
endmodule
